// File: rtl/data_mem_pipe.sv
// Pipelined MEM-stage data memory: valid/ready request/response, byte-enable
// writes, READ_LATENCY-stage in-order response chain, base/bounds/alignment check.
module data_mem_pipe #(
    parameter int WORD_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int DEPTH        = 1024,
    parameter int BASE_ADDR    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ReqValid,
    output logic                      ReqReady,
    input  logic                      ReqWrite,
    input  logic [ADDRESS_SIZE-1:0]   Address,
    input  logic [WORD_SIZE-1:0]      WriteData,
    input  logic [WORD_SIZE/8-1:0]    ByteEn,
    output logic                      RespValid,
    input  logic                      RespReady,
    output logic [WORD_SIZE-1:0]      ReadData,
    output logic                      RespError
);

    localparam int BYTES = WORD_SIZE / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST  = READ_LATENCY - 1;

    localparam logic [ADDRESS_SIZE-1:0] BASE       = ADDRESS_SIZE'(BASE_ADDR);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ADDRESS_SIZE'(BYTES - 1);
    localparam logic [ADDRESS_SIZE:0]   SPAN       = (ADDRESS_SIZE + 1)'(DEPTH * BYTES);

    // Out-of-window or misaligned byte address; off is the base-relative offset.
    function automatic logic addr_error(input logic [ADDRESS_SIZE-1:0] addr,
                                        input logic [ADDRESS_SIZE-1:0] off);
        logic below, beyond, misaligned;
        below      = (addr < BASE);
        beyond     = ({1'b0, off} >= SPAN);
        misaligned = |(off & ALIGN_MASK);
        return below || beyond || misaligned;
    endfunction

    logic [WORD_SIZE-1:0]    mem [DEPTH];

    logic [ADDRESS_SIZE-1:0] off;
    logic [IDX_W-1:0]        idx;
    logic                    req_err;
    logic                    stall;
    logic                    accept;
    logic                    wr_en;

    logic                    vld_p  [READ_LATENCY];
    logic                    err_p  [READ_LATENCY];
    logic [WORD_SIZE-1:0]    data_p [READ_LATENCY];

    assign off     = Address - BASE;
    assign idx     = off[OFFS +: IDX_W];
    assign req_err = addr_error(Address, off);

    assign stall    = RespValid && !RespReady;
    assign ReqReady = !stall;
    assign accept   = ReqValid && ReqReady;
    assign wr_en    = accept && ReqWrite && !req_err && rst_n;

    // Byte-granular write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (ByteEn[b]) begin
                    mem[idx][8*b +: 8] <= WriteData[8*b +: 8];
                end
            end
        end
    end

    // Stage 1 .. READ_LATENCY control: valid and error tags shift as one chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_p[i] <= 1'b0;
                err_p[i] <= 1'b0;
            end
        end else if (!stall) begin
            vld_p[0] <= accept;
            err_p[0] <= accept && req_err;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                err_p[i] <= err_p[i-1];
            end
        end
    end

    // Stage 1 .. READ_LATENCY data: writes and errors carry zero.
    always_ff @(posedge clk) begin
        if (!stall) begin
            data_p[0] <= (accept && !ReqWrite && !req_err) ? mem[idx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                data_p[i] <= data_p[i-1];
            end
        end
    end

    assign RespValid = vld_p[LAST];
    assign RespError = err_p[LAST];
    // Data registers are not reset, so gate them with the valid tag.
    assign ReadData  = vld_p[LAST] ? data_p[LAST] : '0;

endmodule
